addsub_flag_unit: RTL

//   Multi-cycle add/subtract unit producing result plus Z/V/N condition flags for the

---
 rtl/addsub_flag_unit_pkg.sv | 48 ++++
 rtl/addsub_flag_unit_chunk.sv | 21 ++
 rtl/addsub_flag_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/addsub_flag_unit_pkg.sv
// Shared definitions for the chunked add/sub unit and the
// compare/branch stage that consumes its flags.
package addsub_flag_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } flags_t;

  function automatic flags_t calc_flags(
    input logic msb,
    input logic zero,
    input logic c_msb,
    input logic c_out,
    input logic sgn,
    input logic is_sub
  );
    flags_t f;
    f.z = zero;
    f.v = 1'b0;
    f.n = 1'b0;
    priority case (1'b1)
      sgn: begin
        f.v = c_msb ^ c_out;
        f.n = msb ^ f.v;
      end
      // unsigned subtract: no carry out means a borrow, i.e. A < B
      is_sub: begin
        f.v = ~c_out;
        f.n = ~c_out;
      end
      default: f.v = c_out;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/addsub_flag_unit_chunk.sv
// One CHUNK-bit slice of the adder; the top reuses it for every
// chunk of the operands, LSB chunk first.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
  assign sum_o   = full[CHUNK-1:0];
  assign cout_o  = full[CHUNK];
  assign c_msb_o = full[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

endmodule

// File: rtl/addsub_flag_unit.sv
// Multi-cycle add/subtract with Z/V/N flags, CHUNK bits per clock,
// carry held in a register between chunks.
module addsub_flag_unit
  import addsub_flag_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             sgn_q, sgn_d;
  flags_t           flg_q, flg_d;

  logic [31:0]      off;
  logic [CHUNK-1:0] ca, cb, csum;
  logic             cout, cmsb;

  assign off = 32'(idx_q) * 32'(CHUNK);
  assign ca  = a_q[off +: CHUNK];
  assign cb  = b_q[off +: CHUNK];

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i    (ca),
    .b_i    (cb),
    .cin_i  (carry_q),
    .sum_o  (csum),
    .cout_o (cout),
    .c_msb_o(cmsb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    result_d = result_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    sgn_d    = sgn_q;
    flg_d    = flg_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          sub_d   = sub;
          sgn_d   = signed_op;
        end
      end
      ST_RUN: begin
        part_d[off +: CHUNK] = csum;
        carry_d = cout;
        if (idx_q == LAST) begin
          state_d  = ST_DONE;
          result_d = part_d;
          flg_d    = calc_flags(part_d[WIDTH-1], part_d == '0,
                                cmsb, cout, sgn_q, sub_q);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      sgn_q    <= 1'b0;
      flg_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      sgn_q    <= sgn_d;
      flg_q    <= flg_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign z      = flg_q.z;
  assign v      = flg_q.v;
  assign n      = flg_q.n;

endmodule
